fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Shares the single framebuffer (blockram) write port among N_REQ pixel writers (sprite drawer, shot drawer, ...).
//  Grants only while the display is blanking (blank = ~do_read), so writes never collide with scan-out reads.
//  Round-robin between requesters; a holder keeps the port for a burst of up to MAX_BURST pixels.
//  Drives do_write/write_x/write_y/write of the blockram directly.
// PARAMETERS
//  N_REQ      3    number of requesters (2..4)
//  MAX_BURST  16   max pixels written per grant while another requester waits
//  FB_W       320  framebuffer width; x >= FB_W is dropped
//  FB_H       200  framebuffer height; y >= FB_H is dropped
// PORTS
//  clk        in   1         pixel-domain clock (same clk as blockram/display_vga)
//  rst_n      in   1         asynchronous active-low reset
//  blank      in   1         1 = display not reading; writes allowed this cycle
//  req        in   N_REQ     per-requester request; held high while pixels remain
//  req_x      in   9*N_REQ   packed x; requester i at [9*i+:9]
//  req_y      in   8*N_REQ   packed y; requester i at [8*i+:8]
//  req_bit    in   N_REQ     pixel value per requester
//  gnt        out  N_REQ     registered one-hot grant
//  ack        out  N_REQ     comb: pixel consumed this cycle (gnt[i] & req[i] & blank [& ~clear_busy])
//  do_write   out  1         blockram write enable
//  write_x    out  9         blockram write x
//  write_y    out  8         blockram write y
//  write      out  1         blockram write data
//  busy       out  1         registered: a grant is held (or clear running)
// BEHAVIOUR
//  - Reset (rst_n=0, async): gnt=0, busy=0, rr pointer=0, burst_cnt=0, state=IDLE; do_write/ack=0 via comb from gnt=0.
//  - States: IDLE, GRANT (plus CLEAR when FB_CLEAR_EN).
//  - IDLE: if blank & |req, pick first set req searching from rr_ptr upward (wrap mod N_REQ); gnt<=onehot, burst_cnt<=0, ->GRANT.
//    Grant latency: req high in cycle N (blank high) -> gnt high cycle N+1 -> first ack/write cycle N+1.
//  - GRANT (holder h): each cycle with ack[h]: burst_cnt++; the pixel is consumed by the requester that cycle.
//    blank low: gnt held, ack=0, do_write=0, burst_cnt frozen.
//    req[h] low: gnt<=0, rr_ptr<=h+1 (mod N_REQ), ->IDLE (no write that cycle).
//    burst_cnt reaches MAX_BURST-1 on an ack cycle and another req set: gnt<=0, rr_ptr<=h+1, ->IDLE.
//    burst_cnt reaches MAX_BURST-1 and no other req: keep grant, burst_cnt<=0.
//  - Write mux: write_x/write_y/write = req_x/req_y/req_bit of holder; 0 when no grant.
//    do_write = ack[h] & (x < FB_W) & (y < FB_H); out-of-range pixels are acked but dropped.
//  - A new grant is never issued in the same cycle a grant ends: >=1 IDLE cycle between holders.
//  - Requesters must hold req_x/y/bit stable until ack; may change them the cycle after ack.
//  - req rising while blank low: no grant until blank high.
//  - busy = (state != IDLE).
// CONFIGURATION
//  FB_CLEAR_EN defined: adds ports clear_start (in,1, pulse) and clear_busy (out,1, registered).
//    clear_start in IDLE or GRANT -> CLEAR next cycle (current grant dropped, rr_ptr unchanged).
//    CLEAR sweeps x 0..FB_W-1 inner, y 0..FB_H-1 outer, writing 0, one pixel per blank cycle, highest priority;
//    all ack=0 during CLEAR. After (FB_W-1,FB_H-1) written -> IDLE, clear_busy<=0.
//    clear_start during CLEAR is ignored (no restart). Reset clears counters, clear_busy=0.
//  FB_CLEAR_EN undefined: no clear ports, no CLEAR state; CLEAR logic absent.
// TESTING
//  1. req=001, x=5,y=7,bit=1, blank=1 -> gnt=001 next cycle; do_write=1, write_x=5, write_y=7, write=1, ack[0]=1.
//  2. req=011 held, blank=1, MAX_BURST=16 -> req0 gets 16 acks, 1 idle cycle, req1 gets 16 acks, back to req0.
//  3. Holder writing, blank drops for 10 cycles -> do_write=0, ack=0, gnt held; burst_cnt resumes unchanged.
//  4. Holder req x=320,y=0 -> ack=1, do_write=0; x=319,y=199 -> do_write=1.
//  5. rst_n low mid-burst -> gnt=0, do_write=0 immediately; after release req=100 -> grant to req2 from rr_ptr=0 search.
//  6. FB_CLEAR_EN: clear_start while req0 granted -> gnt=0, clear_busy=1; 64000 blank-cycle writes of 0; then IDLE.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Shares the single framebuffer blockram write port among N_REQ pixel writers.
// A grant is only acted on while the display is blanking, so writes never
// collide with scan-out reads. Requesters are served round-robin. A holder keeps
// the port for bursts of up to MAX_BURST pixels while someone else waits.
//
// Optional feature macro: FB_CLEAR_EN
//   When defined, this adds a full-screen clear sweep (clear_start_i/clear_busy_o).
//   The sweep writes 0 to every pixel and has the highest priority.
//
// Ports
//   clk_i         pixel-domain clock (shared with blockram / display)
//   rst_ni        asynchronous active-low reset
//   blank_i       1 = display not reading, writes allowed this cycle
//   req_i         per-requester request, held while pixels remain
//   req_x_i       packed x, requester i at [9*i+:9]
//   req_y_i       packed y, requester i at [8*i+:8]
//   req_bit_i     pixel value per requester
//   clear_start_i (FB_CLEAR_EN) pulse: start a clear sweep
//   clear_busy_o  (FB_CLEAR_EN) registered: clear sweep running
//   gnt_o         registered one-hot grant
//   ack_o         combinational: pixel consumed this cycle
//   do_write_o    blockram write enable
//   write_x_o     blockram write x
//   write_y_o     blockram write y
//   write_o       blockram write data
//   busy_o        registered: grant held or clear running
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 16,
  parameter int FB_W      = 320,
  parameter int FB_H      = 200
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               blank_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [9*N_REQ-1:0] req_x_i,
  input  logic [8*N_REQ-1:0] req_y_i,
  input  logic [N_REQ-1:0]   req_bit_i,
`ifdef FB_CLEAR_EN
  input  logic               clear_start_i,
  output logic               clear_busy_o,
`endif
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   ack_o,
  output logic               do_write_o,
  output logic [8:0]         write_x_o,
  output logic [7:0]         write_y_o,
  output logic               write_o,
  output logic               busy_o
);

  localparam int PTR_W = 2;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [9:0]       FB_W_L    = 10'(FB_W);
  localparam logic [8:0]       FB_H_L    = 9'(FB_H);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(N_REQ - 1);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_CLEAR = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_e;
`endif

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
`ifdef FB_CLEAR_EN
  logic [8:0]         clr_x_q, clr_x_d;
  logic [7:0]         clr_y_q, clr_y_d;
  logic               clr_busy_q, clr_busy_d;
`endif

  logic [PTR_W-1:0]   hold_idx_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic [8:0]         hold_x_s;
  logic [7:0]         hold_y_s;
  logic               hold_bit_s;
  logic               in_range_s;
  logic               pick_found_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [N_REQ-1:0]   pick_oh_s;
  logic               others_req_s;

  // Index of the current holder, decoded from the one-hot grant.
  always_comb begin
    hold_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        hold_idx_s = PTR_W'(i);
      end else begin
        hold_idx_s = hold_idx_s;
      end
    end
  end

  // Round-robin search: first set request starting at rr_q, wrapping mod N_REQ.
  always_comb begin
    int cand;
    pick_found_s = 1'b0;
    pick_idx_s   = {PTR_W{1'b0}};
    pick_oh_s    = {N_REQ{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end else begin
        cand = cand;
      end
      if (!pick_found_s && req_i[cand]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = PTR_W'(cand);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    pick_oh_s[pick_idx_s] = 1'b1;
  end

  assign next_ptr_s   = (hold_idx_s == LAST_REQ) ? {PTR_W{1'b0}} : hold_idx_s + PTR_W'(1);
  assign others_req_s = |(req_i & ~gnt_q);
  assign hold_x_s     = req_x_i[9*hold_idx_s +: 9];
  assign hold_y_s     = req_y_i[8*hold_idx_s +: 8];
  assign hold_bit_s   = req_bit_i[hold_idx_s];
  assign in_range_s   = ({1'b0, hold_x_s} < FB_W_L) && ({1'b0, hold_y_s} < FB_H_L);

  // A pixel is consumed whenever the holder requests during blanking. gnt_q is
  // always zero during a clear sweep, so a clear also suppresses ack.
  assign ack_o = gnt_q & req_i & {N_REQ{blank_i}};

  // Blockram write-port mux: clear sweep, current holder, or idle zeros.
  always_comb begin
    do_write_o = 1'b0;
    write_x_o  = 9'd0;
    write_y_o  = 8'd0;
    write_o    = 1'b0;
`ifdef FB_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      do_write_o = blank_i;
      write_x_o  = clr_x_q;
      write_y_o  = clr_y_q;
      write_o    = 1'b0;
    end else
`endif
    if (|gnt_q) begin
      // Out-of-range pixels are still acked but never reach the blockram.
      do_write_o = ack_o[hold_idx_s] & in_range_s;
      write_x_o  = hold_x_s;
      write_y_o  = hold_y_s;
      write_o    = hold_bit_s;
    end else begin
      do_write_o = 1'b0;
    end
  end

  // Next-state logic for arbitration, burst counting and the clear sweep.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
`ifdef FB_CLEAR_EN
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (blank_i && pick_found_s) begin
          gnt_d   = pick_oh_s;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req_i[hold_idx_s]) begin
          gnt_d   = {N_REQ{1'b0}};
          rr_d    = next_ptr_s;
          state_d = ST_IDLE;
        end else if (blank_i) begin
          if (cnt_q == BURST_END) begin
            if (others_req_s) begin
              gnt_d   = {N_REQ{1'b0}};
              rr_d    = next_ptr_s;
              state_d = ST_IDLE;
            end else begin
              // Nobody waiting: keep the port and start a fresh burst.
              cnt_d = {CNT_W{1'b0}};
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Display reading: grant held, burst count frozen.
          cnt_d = cnt_q;
        end
      end
`ifdef FB_CLEAR_EN
      ST_CLEAR: begin
        if (blank_i) begin
          if (clr_x_q == 9'(FB_W - 1)) begin
            clr_x_d = 9'd0;
            if (clr_y_q == 8'(FB_H - 1)) begin
              clr_y_d = 8'd0;
              state_d = ST_IDLE;
            end else begin
              clr_y_d = clr_y_q + 8'd1;
            end
          end else begin
            clr_x_d = clr_x_q + 9'd1;
          end
        end else begin
          clr_x_d = clr_x_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {N_REQ{1'b0}};
      end
    endcase
`ifdef FB_CLEAR_EN
    // Clear pre-empts any grant and leaves the round-robin pointer alone.
    // A start pulse during a sweep is ignored.
    if (clear_start_i && (state_q != ST_CLEAR)) begin
      state_d = ST_CLEAR;
      gnt_d   = {N_REQ{1'b0}};
      rr_d    = rr_q;
      cnt_d   = {CNT_W{1'b0}};
      clr_x_d = 9'd0;
      clr_y_d = 8'd0;
    end else begin
      rr_d = rr_d;
    end
    clr_busy_d = (state_d == ST_CLEAR);
`endif
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_q      <= {N_REQ{1'b0}};
      rr_q       <= {PTR_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      busy_q     <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_x_q    <= 9'd0;
      clr_y_q    <= 8'd0;
      clr_busy_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
`ifdef FB_CLEAR_EN
      clr_x_q    <= clr_x_d;
      clr_y_q    <= clr_y_d;
      clr_busy_q <= clr_busy_d;
`endif
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;
`ifdef FB_CLEAR_EN
  assign clear_busy_o = clr_busy_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for fb_write_arbiter (N_REQ=3, MAX_BURST=16, 320x200).
// Part 1 is a cycle-by-cycle vector table: latency, range drop, blank hold,
// release and round-robin order. Part 2 is a mid-burst asynchronous reset.
// Part 3 is a two-requester burst run, checked against an expected write queue,
// with a blanking gap inserted mid-burst. Part 4 (FB_CLEAR_EN only) is a clear
// sweep.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blank;
  logic [2:0]  req;
  logic [26:0] req_x;
  logic [23:0] req_y;
  logic [2:0]  req_bit;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic        do_write;
  logic [8:0]  wx;
  logic [7:0]  wy;
  logic        wbit;
  logic        busy;
`ifdef FB_CLEAR_EN
  logic        clear_start;
  logic        clear_busy;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(.N_REQ(3), .MAX_BURST(16), .FB_W(320), .FB_H(200)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .blank_i      (blank),
    .req_i        (req),
    .req_x_i      (req_x),
    .req_y_i      (req_y),
    .req_bit_i    (req_bit),
`ifdef FB_CLEAR_EN
    .clear_start_i(clear_start),
    .clear_busy_o (clear_busy),
`endif
    .gnt_o        (gnt),
    .ack_o        (ack),
    .do_write_o   (do_write),
    .write_x_o    (wx),
    .write_y_o    (wy),
    .write_o      (wbit),
    .busy_o       (busy)
  );

  typedef struct {
    logic            blank;
    logic [2:0]      req;
    logic [2:0][8:0] x;
    logic [2:0][7:0] y;
    logic [2:0]      b;
    logic [25:0]     exp; // {gnt, ack, do_write, write_x, write_y, write, busy}
  } vec_t;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic       b;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] pk(input logic [2:0] g, input logic [2:0] a, input logic dw,
                                     input logic [8:0] x, input logic [7:0] y, input logic w,
                                     input logic bz);
    return {g, a, dw, x, y, w, bz};
  endfunction

  task automatic add(input logic bl, input logic [2:0] rq,
                     input int x0, input int y0, input logic b0,
                     input int x1, input int y1, input logic b1,
                     input int x2, input int y2, input logic b2,
                     input logic [25:0] e);
    vec_t v;
    v.blank = bl;
    v.req   = rq;
    v.x[0] = 9'(x0); v.y[0] = 8'(y0);
    v.x[1] = 9'(x1); v.y[1] = 8'(y1);
    v.x[2] = 9'(x2); v.y[2] = 8'(y2);
    v.b   = {b2, b1, b0};
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    blank   = 1'b0;
    req     = 3'b000;
    req_x   = 27'd0;
    req_y   = 24'd0;
    req_bit = 3'b000;
`ifdef FB_CLEAR_EN
    clear_start = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int pix[3];

  task automatic drive_pix();
    for (int i = 0; i < 3; i++) begin
      req_x[9*i +: 9] = 9'(pix[i]);
      req_y[8*i +: 8] = 8'(20 * i);
      req_bit[i]      = pix[i][0];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_cnt;
    bit started;
    wr_t got;
    wr_t e;

    // ---------------- Part 1: vector table ----------------
    add(1'b1, 3'b000,   0,  0,1'b0, 0,0,1'b0,   0, 0,1'b0, pk(3'b000,3'b000,1'b0,  9'd0,  8'd0,1'b0,1'b0));
    add(1'b1, 3'b001,   5,  7,1'b1, 0,0,1'b0,   0, 0,1'b0, pk(3'b000,3'b000,1'b0,  9'd0,  8'd0,1'b0,1'b0));
    add(1'b1, 3'b001,   5,  7,1'b1, 0,0,1'b0,   0, 0,1'b0, pk(3'b001,3'b001,1'b1,  9'd5,  8'd7,1'b1,1'b1));
    add(1'b1, 3'b001, 320,  0,1'b1, 0,0,1'b0,   0, 0,1'b0, pk(3'b001,3'b001,1'b0,9'd320,  8'd0,1'b1,1'b1));
    add(1'b1, 3'b001, 319,199,1'b0, 0,0,1'b0,   0, 0,1'b0, pk(3'b001,3'b001,1'b1,9'd319,8'd199,1'b0,1'b1));
    add(1'b1, 3'b001,   0,200,1'b1, 0,0,1'b0,   0, 0,1'b0, pk(3'b001,3'b001,1'b0,  9'd0,8'd200,1'b1,1'b1));
    add(1'b0, 3'b001,  10, 10,1'b1, 0,0,1'b0,   0, 0,1'b0, pk(3'b001,3'b000,1'b0, 9'd10, 8'd10,1'b1,1'b1));
    add(1'b1, 3'b000,  10, 10,1'b1, 0,0,1'b0,   0, 0,1'b0, pk(3'b001,3'b000,1'b0, 9'd10, 8'd10,1'b1,1'b1));
    add(1'b1, 3'b101,  10, 10,1'b1, 0,0,1'b0, 100,50,1'b1, pk(3'b000,3'b000,1'b0,  9'd0,  8'd0,1'b0,1'b0));
    add(1'b1, 3'b101,  10, 10,1'b1, 0,0,1'b0, 100,50,1'b1, pk(3'b100,3'b100,1'b1,9'd100, 8'd50,1'b1,1'b1));
    add(1'b0, 3'b111,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b100,3'b000,1'b0,9'd100, 8'd50,1'b1,1'b1));
    add(1'b1, 3'b011,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b100,3'b000,1'b0,9'd100, 8'd50,1'b1,1'b1));
    add(1'b0, 3'b011,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b000,3'b000,1'b0,  9'd0,  8'd0,1'b0,1'b0));
    add(1'b0, 3'b011,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b000,3'b000,1'b0,  9'd0,  8'd0,1'b0,1'b0));
    add(1'b1, 3'b011,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b000,3'b000,1'b0,  9'd0,  8'd0,1'b0,1'b0));
    add(1'b1, 3'b011,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b001,3'b001,1'b1, 9'd10, 8'd10,1'b1,1'b1));
    add(1'b1, 3'b010,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b001,3'b000,1'b0, 9'd10, 8'd10,1'b1,1'b1));
    add(1'b1, 3'b010,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b000,3'b000,1'b0,  9'd0,  8'd0,1'b0,1'b0));
    add(1'b1, 3'b010,  10, 10,1'b1, 1,1,1'b0, 100,50,1'b1, pk(3'b010,3'b010,1'b1,  9'd1,  8'd1,1'b0,1'b1));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      blank   = vecs[i].blank;
      req     = vecs[i].req;
      req_x   = vecs[i].x;
      req_y   = vecs[i].y;
      req_bit = vecs[i].b;
      @(negedge clk);
      check($sformatf("vec%0d", i), {gnt, ack, do_write, wx, wy, wbit, busy}, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // ---------------- Part 2: async reset mid-burst ----------------
    rst_n = 1'b0;
    #2;
    check("rst_gnt", gnt, 3'b000);
    check("rst_do_write", do_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    blank   = 1'b1;
    req     = 3'b100;
    req_x   = {9'd100, 9'd0, 9'd0};
    req_y   = {8'd50, 8'd0, 8'd0};
    req_bit = 3'b100;
    @(negedge clk);
    check("post_rst_wait", gnt, 3'b000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_grant", {gnt, ack, do_write}, {3'b100, 3'b100, 1'b1});

    // ---------------- Part 3: burst fairness with blanking gap ----------------
    for (int k = 0; k < 16; k++) exp_q.push_back(wr_t'{9'(k), 8'd0, k[0]});
    for (int k = 0; k < 16; k++) exp_q.push_back(wr_t'{9'(k), 8'd20, k[0]});
    for (int k = 16; k < 32; k++) exp_q.push_back(wr_t'{9'(k), 8'd0, k[0]});
    do_reset();
    pix = '{0, 0, 0};
    blank = 1'b1;
    req   = 3'b011;
    drive_pix();
    idle_cnt = 0;
    started  = 1'b0;
    for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (do_write) begin
        got = {wx, wy, wbit};
        e = exp_q.pop_front();
        check("burst_write", got, e);
      end
      if (!blank) check("blank_hold", {gnt, ack, do_write}, {3'b001, 3'b000, 1'b0});
      if (gnt != 3'b000) started = 1'b1;
      else if (started) idle_cnt++;
      for (int i = 0; i < 3; i++) if (ack[i]) pix[i]++;
      @(posedge clk);
      #1;
      blank = !((cyc + 1) >= 10 && (cyc + 1) < 20);
      drive_pix();
    end
    check("burst_drain", exp_q.size(), 0);
    check("burst_idle_gaps", idle_cnt, 2);

`ifdef FB_CLEAR_EN
    // ---------------- Part 4: clear sweep ----------------
    begin
      int ex, ey, writes, bad, ackbad, cyc;
      do_reset();
      blank   = 1'b1;
      req     = 3'b001;
      req_x   = 27'd1;
      req_y   = 24'd1;
      req_bit = 3'b001;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("clr_pre_grant", gnt, 3'b001);
      @(posedge clk);
      #1 clear_start = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 clear_start = 1'b0;
      @(negedge clk);
      check("clr_start", {gnt, clear_busy}, {3'b000, 1'b1});
      ex = 0; ey = 0; writes = 0; bad = 0; ackbad = 0; cyc = 0;
      while (clear_busy && cyc < 80000) begin
        if (do_write) begin
          if (wx != 9'(ex) || wy != 8'(ey) || wbit != 1'b0) bad++;
          writes++;
          if (ex == 319) begin ex = 0; ey++; end
          else ex++;
        end
        if (ack != 3'b000) ackbad++;
        @(posedge clk);
        #1;
        blank       = (cyc % 7) != 3;
        clear_start = (cyc == 100);
        cyc++;
        @(negedge clk);
      end
      clear_start = 1'b0;
      check("clr_writes", writes, 64000);
      check("clr_coords", bad, 0);
      check("clr_ack_quiet", ackbad, 0);
      check("clr_done_idle", {clear_busy, busy}, 2'b00);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
